// File: rtl/mem_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single native valid/ready memory port.
// One access in flight at a time; a per-access timeout aborts hung slaves with an error reply.
module mem_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        err,
    output logic        err_master
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_grant;
    logic               r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_s_valid;
    logic               r_s_instr;
    logic [31:0]        r_s_addr;
    logic [31:0]        r_s_wdata;
    logic [3:0]         r_s_wstrb;
    logic               r_m0_ready;
    logic               r_m1_ready;
    logic [31:0]        r_m0_rdata;
    logic [31:0]        r_m1_rdata;
    logic               r_err;
    logic               r_err_master;

    logic               w_any;
    logic               w_winner;
    logic               w_timeout;
    logic               w_instr;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wstrb;

    // Winner selection: on a tie the master that did not win last time goes next.
    always_comb begin
        w_any = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
            w_winner = ~r_last_grant;
        end else if (m1_valid) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
        w_instr   = w_winner ? m1_instr : m0_instr;
        w_addr    = w_winner ? m1_addr  : m0_addr;
        w_wdata   = w_winner ? m1_wdata : m0_wdata;
        w_wstrb   = w_winner ? m1_wstrb : m0_wstrb;
        w_timeout = (TIMEOUT_CYCLES != 32'd0) && (r_cnt == CNT_LAST);
    end

    // Arbitration FSM with registered slave-side and master-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= {CNT_W{1'b0}};
            r_s_valid    <= 1'b0;
            r_s_instr    <= 1'b0;
            r_s_addr     <= 32'd0;
            r_s_wdata    <= 32'd0;
            r_s_wstrb    <= 4'd0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
            r_m0_rdata   <= 32'd0;
            r_m1_rdata   <= 32'd0;
            r_err        <= 1'b0;
            r_err_master <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_s_valid    <= 1'b1;
                        r_s_instr    <= w_instr;
                        r_s_addr     <= w_addr;
                        r_s_wdata    <= w_wdata;
                        r_s_wstrb    <= w_wstrb;
                        r_cnt        <= {CNT_W{1'b0}};
                        r_state      <= BUSY;
                    end else begin
                        r_state      <= IDLE;
                    end
                end
                BUSY: begin
                    // A slave answer in the timeout cycle still counts as a real completion.
                    if (s_ready) begin
                        r_s_valid <= 1'b0;
                        if (r_grant) begin
                            r_m1_ready <= 1'b1;
                            r_m1_rdata <= s_rdata;
                        end else begin
                            r_m0_ready <= 1'b1;
                            r_m0_rdata <= s_rdata;
                        end
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_s_valid    <= 1'b0;
                        r_err        <= 1'b1;
                        r_err_master <= r_grant;
                        if (r_grant) begin
                            r_m1_ready <= 1'b1;
                            r_m1_rdata <= ERR_RDATA;
                        end else begin
                            r_m0_ready <= 1'b1;
                            r_m0_rdata <= ERR_RDATA;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= BUSY;
                    end
                end
                RESP: begin
                    r_m0_ready <= 1'b0;
                    r_m1_ready <= 1'b0;
                    r_err      <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_s_valid  <= 1'b0;
                    r_m0_ready <= 1'b0;
                    r_m1_ready <= 1'b0;
                    r_err      <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign s_valid    = r_s_valid;
    assign s_instr    = r_s_instr;
    assign s_addr     = r_s_addr;
    assign s_wdata    = r_s_wdata;
    assign s_wstrb    = r_s_wstrb;
    assign m0_ready   = r_m0_ready;
    assign m1_ready   = r_m1_ready;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;
    assign err        = r_err;
    assign err_master = r_err_master;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter (built with a 4-cycle timeout).
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready, err, err_master;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_rr_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .err(err), .err_master(err_master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        w;

        reset = 1'b1;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
        s_ready = 1'b0; s_rdata = 32'd0;
        tick(); tick();
        check("rst_s_valid", {31'd0, s_valid}, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_wdata", s_wdata, 32'd0);
        check("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        check("rst_m_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_err", {30'd0, err, err_master}, 32'd0);
        reset = 1'b0;
        tick();

        // Single read by m0 with a two-cycle slave wait.
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0; m0_instr = 1'b1;
        tick();
        check("rd_s_valid", {31'd0, s_valid}, 32'd1);
        check("rd_s_addr", s_addr, 32'h0000_0010);
        check("rd_s_instr", {31'd0, s_instr}, 32'd1);
        tick();
        check("rd_wait_s_valid", {31'd0, s_valid}, 32'd1);
        check("rd_wait_m0_ready", {31'd0, m0_ready}, 32'd0);
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        tick();
        check("rd_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        check("rd_m1_ready", {31'd0, m1_ready}, 32'd0);
        check("rd_s_valid_low", {31'd0, s_valid}, 32'd0);
        s_ready = 1'b0;
        tick();
        m0_valid = 1'b0; m0_instr = 1'b0;
        check("rd_m0_ready_pulse", {31'd0, m0_ready}, 32'd0);
        check("rd_m0_rdata_hold", m0_rdata, 32'h1234_5678);

        // Simultaneous requests straight out of reset: m0 wins the first tie.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'hF; m0_wdata = 32'hA5A5_A5A5;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_wstrb = 4'h0; m1_wdata = 32'h0;
        tick();
        check("sim_first_addr", s_addr, 32'h0000_0100);
        check("sim_first_wstrb", {28'd0, s_wstrb}, 32'h0000_000F);
        check("sim_first_wdata", s_wdata, 32'hA5A5_A5A5);
        s_ready = 1'b1; s_rdata = 32'h1111_1111;
        tick();
        check("sim_m0_ready", {30'd0, m0_ready, m1_ready}, 32'd2);
        check("sim_resp_s_valid", {31'd0, s_valid}, 32'd0);
        s_ready = 1'b0;
        tick();
        m0_valid = 1'b0;
        check("sim_idle_s_valid", {31'd0, s_valid}, 32'd0);
        check("sim_m1_waits", {31'd0, m1_ready}, 32'd0);
        tick();
        check("sim_second_addr", s_addr, 32'h0000_0200);
        check("sim_second_wstrb", {28'd0, s_wstrb}, 32'd0);
        check("sim_second_s_valid", {31'd0, s_valid}, 32'd1);
        s_ready = 1'b1; s_rdata = 32'h2222_2222;
        tick();
        check("sim_m1_ready", {30'd0, m0_ready, m1_ready}, 32'd1);
        check("sim_m1_rdata", m1_rdata, 32'h2222_2222);
        check("sim_m0_rdata_hold", m0_rdata, 32'h1111_1111);
        s_ready = 1'b0; m1_valid = 1'b0;
        tick();

        // Continuous contention: grants alternate, s_* stable while BUSY.
        m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_wstrb = 4'h3;
        m1_valid = 1'b1; m1_addr = 32'h0000_2000; m1_wstrb = 4'h0;
        for (int i = 0; i < 16; i++) begin
            w = i[0];
            exp_addr = w ? 32'h0000_2000 : 32'h0000_1000;
            tick();
            check("rr_s_valid", {31'd0, s_valid}, 32'd1);
            check("rr_grant_addr", s_addr, exp_addr);
            m0_addr = 32'hFFFF_FFFF; m1_addr = 32'hFFFF_FFFF; m0_wstrb = 4'hC;
            tick();
            check("rr_addr_stable", s_addr, exp_addr);
            check("rr_wstrb_stable", {28'd0, s_wstrb}, w ? 32'd0 : 32'd3);
            m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000; m0_wstrb = 4'h3;
            s_ready = 1'b1; s_rdata = 32'h0000_0100 + i;
            tick();
            check("rr_ready", {30'd0, m0_ready, m1_ready}, w ? 32'd1 : 32'd2);
            check("rr_rdata", w ? m1_rdata : m0_rdata, 32'h0000_0100 + i);
            s_ready = 1'b0;
            tick();
            check("rr_idle_s_valid", {31'd0, s_valid}, 32'd0);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();

        // Timeout: slave never answers m1.
        m1_valid = 1'b1; m1_addr = 32'h0000_0300; m1_wstrb = 4'h0;
        tick();
        check("to_s_valid_1", {31'd0, s_valid}, 32'd1);
        tick();
        check("to_s_valid_2", {31'd0, s_valid}, 32'd1);
        tick();
        check("to_s_valid_3", {31'd0, s_valid}, 32'd1);
        tick();
        check("to_s_valid_4", {31'd0, s_valid}, 32'd1);
        check("to_no_err_yet", {31'd0, err}, 32'd0);
        tick();
        check("to_s_valid_drop", {31'd0, s_valid}, 32'd0);
        check("to_m1_ready", {30'd0, m0_ready, m1_ready}, 32'd1);
        check("to_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_err_master", {31'd0, err_master}, 32'd1);
        tick();
        m1_valid = 1'b0;
        check("to_err_pulse", {31'd0, err}, 32'd0);
        check("to_err_master_hold", {31'd0, err_master}, 32'd1);
        check("to_m1_ready_pulse", {31'd0, m1_ready}, 32'd0);

        // Next request after the timeout proceeds normally.
        m0_valid = 1'b1; m0_addr = 32'h0000_0400; m0_wstrb = 4'h0;
        tick();
        check("post_to_addr", s_addr, 32'h0000_0400);
        s_ready = 1'b1; s_rdata = 32'h4444_4444;
        tick();
        check("post_to_ready", {30'd0, m0_ready, m1_ready}, 32'd2);
        check("post_to_rdata", m0_rdata, 32'h4444_4444);
        check("post_to_no_err", {31'd0, err}, 32'd0);
        s_ready = 1'b0;
        tick();
        m0_valid = 1'b0;

        // Slave answers in the very cycle the timeout would fire.
        m0_valid = 1'b1; m0_addr = 32'h0000_0500;
        tick();
        tick();
        tick();
        tick();
        check("edge_s_valid", {31'd0, s_valid}, 32'd1);
        s_ready = 1'b1; s_rdata = 32'h5555_5555;
        tick();
        check("edge_ready", {30'd0, m0_ready, m1_ready}, 32'd2);
        check("edge_rdata", m0_rdata, 32'h5555_5555);
        check("edge_no_err", {31'd0, err}, 32'd0);
        s_ready = 1'b0;
        tick();
        m0_valid = 1'b0;
        check("edge_no_err_after", {31'd0, err}, 32'd0);

        // Reset during BUSY clears everything at once; m0 wins the first tie afterwards.
        m0_valid = 1'b1; m0_addr = 32'h0000_0700; m1_addr = 32'h0000_0800;
        tick();
        check("mid_busy_s_valid", {31'd0, s_valid}, 32'd1);
        #2;
        reset = 1'b1;
        m1_valid = 1'b1;
        #1;
        check("mid_async_s_valid", {31'd0, s_valid}, 32'd0);
        check("mid_async_s_addr", s_addr, 32'd0);
        check("mid_async_err_master", {31'd0, err_master}, 32'd0);
        check("mid_async_m0_rdata", m0_rdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_tie_addr", s_addr, 32'h0000_0700);
        s_ready = 1'b1; s_rdata = 32'h7777_7777;
        tick();
        check("mid_tie_ready", {30'd0, m0_ready, m1_ready}, 32'd2);
        check("mid_tie_rdata", m0_rdata, 32'h7777_7777);
        check("mid_no_err", {31'd0, err}, 32'd0);
        s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one native valid/ready memory port between two bus masters (m0, m1), e.g. the core and a DMA/trace-dump engine, in front of the testbench RAM/MMIO model.
- Each master port presents the same native valid/ready protocol as the core memory port, so existing masters connect unmodified.
- Round-robin arbitration; one outstanding transaction at a time; all slave-side outputs are registered.
- Per-transaction timeout: a hung slave terminates the access with an error response instead of stalling forever.

Parameters:
TIMEOUT_CYCLES, 64, cycles s_valid may stay high without s_ready before abort; 0 disables the timeout
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on timeout

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
m0_valid  input  1  master 0 request
m0_instr  input  1  master 0 instruction-fetch flag
m0_addr  input  32  master 0 byte address
m0_wdata  input  32  master 0 write data
m0_wstrb  input  4  master 0 byte strobes; 0 = read
m0_ready  output  1  master 0 completion pulse
m0_rdata  output  32  master 0 read data, valid while m0_ready
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same as m0_*, for master 1
s_valid  output  1  slave request
s_instr  output  1  forwarded instr flag
s_addr  output  32  forwarded address
s_wdata  output  32  forwarded write data
s_wstrb  output  4  forwarded strobes
s_ready  input  1  slave completion
s_rdata  input  32  slave read data, sampled when s_ready=1
err  output  1  one-cycle pulse on timeout abort
err_master  output  1  index of the master that owned the aborted access; holds until next err

Behaviour:
- Reset values: s_valid=0, s_instr=0, s_addr=0, s_wdata=0, s_wstrb=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, err=0, err_master=0, state=IDLE, last_grant=1 (so m0 wins the first tie), timeout counter=0.
- States: IDLE, BUSY, RESP.
- IDLE: if any mX_valid is high, select the winner and go to BUSY.
  - Only one master valid: that master wins.
  - Both valid: the master != last_grant wins.
  - On the transition: grant<=winner, last_grant<=winner; register the winner's addr/wdata/wstrb/instr onto s_*; s_valid<=1; counter<=0.
- BUSY:
  - s_valid=1 and s_* are held stable, regardless of master input changes.
  - If s_ready=1: s_valid<=0; rdata register<=s_rdata; go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: s_valid<=0; rdata<=ERR_RDATA; err<=1; err_master<=grant; go to RESP.
  - Else: counter<=counter+1.
  - If s_ready and the timeout fall in the same cycle, s_ready wins: no err, real data returned.
- RESP:
  - m[grant]_ready=1 for exactly one cycle, with m[grant]_rdata = latched data; the other master's ready stays 0.
  - Next state is IDLE.
- Arbitration latency:
  - Request-to-s_valid = 1 cycle.
  - s_ready-to-mX_ready = 1 cycle.
  - Minimum transaction = 3 cycles; IDLE re-arbitrates the cycle after RESP.
- Masters drop valid the cycle after ready, so a completed request is never re-granted. A master that keeps valid high after ready is treated as a new request.
- A request from the non-granted master waits, with no ready, until the owner finishes. Fairness: with both masters requesting continuously, grants strictly alternate.
- The slave is never presented two accesses back-to-back without s_valid low for at least 2 cycles (RESP, IDLE).
- mX_rdata holds its last value outside ready cycles; m_rdata for writes carries s_rdata as sampled (don't-care to masters).
- reset asserted mid-transaction: all state clears immediately (async); s_valid drops without waiting for s_ready; no ready or err is issued for the aborted access.
- Counter width is clog2(TIMEOUT_CYCLES)+1. With TIMEOUT_CYCLES=0 the counter is never compared and err stays 0.

Test Plan:
- Single read: m0 reads 0x0000_0010, slave returns 0x1234_5678 with 2-cycle wait -> s_valid 1 cycle after m0_valid; m0_ready one cycle after s_ready with m0_rdata=0x1234_5678; m1_ready never asserts.
- Simultaneous requests from reset: m0 write 0x100 (wstrb=4'hF, wdata=0xA5A5A5A5), m1 read 0x200 -> m0 served first, then m1; s_addr sequence 0x100, 0x200; s_wstrb 4'hF then 4'h0.
- Continuous contention: both masters hold valid for 8 transactions each -> grants alternate m0, m1, m0, ...; no master starves; s_* stable throughout each BUSY.
- Timeout: TIMEOUT_CYCLES=4, slave never answers m1 -> s_valid drops after exactly 4 BUSY cycles; m1_ready pulse with m1_rdata=0xDEADBEEF; err 1-cycle pulse with err_master=1; next request proceeds normally.
- Ready on the timeout cycle: s_ready arrives in the 4th BUSY cycle (TIMEOUT_CYCLES=4) -> real data returned; err stays 0.
- Reset mid-transaction: assert reset during BUSY -> all outputs 0 asynchronously, state IDLE; after release, m0 wins the first tie again.
